nibble_serial_add_ctrl: RTL and testbench
=========================================

Name: nibble_serial_add_ctrl

Overview:
- Sequencer that computes one wide add or subtract using a single shared 4-bit ripple-carry adder slice, one nibble per clock, least-significant nibble first.
- The block latches the operands and drives the slice's a/b/c inputs each cycle. It captures sum4/carry4 and chains the carry between cycles through a register.
- It sits between a requesting unit (start/done handshake) and the combinational 4-bit adder.

Parameters:
- NIBBLES, 4, operand width in nibbles; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk      in   1   rising-edge clock
- rst      in   1   synchronous, active-high reset
- start    in   1   request; sampled only in IDLE
- sub      in   1   0 = A+B+cin, 1 = A-B (cin ignored)
- cin      in   1   carry-in for add
- op_a     in   W   operand A
- op_b     in   W   operand B
- busy     out  1   high while in RUN
- done     out  1   one-cycle pulse, result valid
- sum      out  W   result register
- cout     out  1   final carry (for sub: 1 = no borrow)
- add_a    out  4   to adder slice input a
- add_b    out  4   to adder slice input b
- add_c    out  1   to adder slice carry-in c
- add_sum  in   4   from adder slice sum4
- add_carry in  1   from adder slice carry4

Behaviour:
- The attached slice is purely combinational: add_sum/add_carry respond to add_a/add_b/add_c within the same cycle.
- Reset: rst high at a clk edge forces the state to IDLE, with:
  - busy=0, done=0, sum=0, cout=0, add_a=0, add_b=0, add_c=0;
  - index counter=0, carry reg=0, operand regs=0.
  - rst has priority over every other input, including mid-RUN; an aborted operation produces no done.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - latch A=op_a;
  - latch B=op_b, or ~op_b if sub=1;
  - carry reg = sub ? 1 : cin;
  - idx=0; next state RUN.
  - start=0 stays in IDLE.
- RUN, idx=i:
  - add_a = A[4i+3:4i], add_b = B[4i+3:4i], add_c = carry reg; busy=1.
  - At the edge: sum[4i+3:4i] <= add_sum, carry reg <= add_carry, idx <= i+1.
  - At the edge with i=NIBBLES-1: cout <= add_carry, idx <= 0, next state DONE.
- DONE: done=1 for exactly one cycle, busy=0; next state IDLE unconditionally.
- Latency: RUN occupies edges E0+1..E0+NIBBLES; done is high in the cycle after edge E0+NIBBLES. Back-to-back throughput is one operation per NIBBLES+2 cycles.
- start is ignored in RUN and DONE; it is neither queued nor able to corrupt latched operands. op_a/op_b/sub/cin may change freely after E0.
- add_a/add_b/add_c are 0 outside RUN.
- sum is partially updated during RUN and is valid only from the done cycle until the next accepted start. sum and cout hold their values in IDLE.
- Arithmetic: the result is modulo 2^W. Overflow is indicated only via cout; there is no signed-overflow flag.
- NIBBLES=1: RUN lasts one cycle; the same rules apply.
- idx counter width is clog2(NIBBLES) with a minimum of 1. idx must never exceed NIBBLES-1.

Test Plan (NIBBLES=4, bench instantiates a behavioural 4-bit adder on add_*):
- Add, no carry: op_a=0x1234, op_b=0x4321, cin=0, sub=0, start at E0.
  - busy high for 4 cycles; done pulses in the cycle after E0+4.
  - sum=0x5555, cout=0; add_a sequence observed as 4,3,2,1.
- Full carry ripple: 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1. add_c sequence is 0,1,1,1.
- Carry-in and subtract:
  - 0x00FF+0x0000 with cin=1 -> sum=0x0100, cout=0.
  - sub: 0x1000-0x0001 -> sum=0x0FFF, cout=1.
  - sub: 0x0001-0x0002 -> sum=0xFFFF, cout=0.
- Start while busy: second start with different operands at E0+2 and again in the DONE cycle.
  - Both are ignored; the result equals the first operation.
  - A new start in the following IDLE cycle is accepted.
- Reset mid-operation: rst at E0+2 -> next cycle all outputs 0 with no done pulse. A following start on 0x0F0F+0x0101 returns 0x1010, cout=0.
- Randomised: 1000 random add/sub operations with random cin and random start gaps, checked against a W-bit reference model for sum and cout.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_add_ctrl
//
// Sequencer that performs one W-bit add or subtract (W = 4*NIBBLES) through
// a single, external, purely combinational 4-bit ripple-carry adder slice.
// The operation proceeds one nibble per clock, least-significant nibble first.
// The carry between nibbles is chained through an internal register.
//
// Subtraction is A + ~B + 1. The operand B is inverted when it is latched, and
// the carry register is preset to 1. A final carry of 1 therefore means
// "no borrow".
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (priority over everything)
//   start      request, sampled only in IDLE
//   sub        0 = A+B+cin, 1 = A-B (cin ignored)
//   cin        carry-in for add
//   op_a/op_b  W-bit operands, latched on the accepted start
//   busy       high while the nibble loop runs
//   done       one-cycle pulse, sum/cout valid
//   sum        W-bit result register (valid from done until next start)
//   cout       final carry out
//   add_a/b/c  drive the adder slice (all zero outside RUN)
//   add_sum    slice sum4 (combinational response to add_a/b/c)
//   add_carry  slice carry4
// -----------------------------------------------------------------------------
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sub,
  input  logic                   cin,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_c,
  input  logic [3:0]             add_sum,
  input  logic                   add_carry
);

  localparam int W     = 4 * NIBBLES;
  // A one-nibble operand still needs a 1-bit counter so the vector is legal.
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [W-1:0]     a_q,     a_d;
  logic [W-1:0]     b_q,     b_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     sum_q,   sum_d;
  logic             cout_q,  cout_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic [3:0]       add_a_q, add_a_d;
  logic [3:0]       add_b_q, add_b_d;

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // The slice inputs are registered. Each time idx changes, the nibble for the
  // new index is loaded, so add_a/add_b always line up with idx_q while in RUN.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case; a path that leaves
    // one unassigned would infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    add_a_d = '0;
    add_b_d = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = sub ? ~op_b : op_b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          add_a_d = a_d[3:0];
          add_b_d = b_d[3:0];
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = add_sum;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_carry;
          // Clearing the carry here keeps add_c low outside RUN.
          carry_d = 1'b0;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          carry_d = add_carry;
          idx_d   = idx_q + 1'b1;
          add_a_d = a_q[{idx_d, 2'b00} +: 4];
          add_b_d = b_q[{idx_d, 2'b00} +: 4];
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let every flop sample the pre-edge
    // values, whatever the order of the assignments below.
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      add_a_q <= '0;
      add_b_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign add_a = add_a_q;
  assign add_b = add_b_q;
  assign add_c = carry_q;

  // The counter must never address past the top nibble.
  a_idx_range: assert property (@(posedge clk) disable iff (rst)
    idx_q <= LAST_IDX);

  // The slice inputs are quiet whenever the loop is not running.
  a_quiet_idle: assert property (@(posedge clk) disable iff (rst)
    (state_q != S_RUN) |-> (add_a_q == 4'd0 && add_b_q == 4'd0 && !carry_q));

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_add_ctrl
//
// Directed and random checks of nibble_serial_add_ctrl with NIBBLES=4. A
// behavioural 4-bit adder is attached to the add_* ports. Inputs are driven
// and outputs sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_nibble_serial_add_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_c;
  logic [3:0]   add_sum;
  logic         add_carry;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .cin       (cin),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_c     (add_c),
    .add_sum   (add_sum),
    .add_carry (add_carry)
  );

  // Combinational 4-bit adder slice.
  assign {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_c};

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] seq_a [NIBBLES];
  logic       seq_c [NIBBLES];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one operation from IDLE and follows it cycle by cycle. busy must be
  // high for exactly NIBBLES cycles, and done must pulse in the cycle after.
  // The slice inputs seen in each RUN cycle are recorded.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic ci,
                       input logic [W-1:0] exp_sum, input logic exp_cout,
                       input string tag);
    start = 1'b1; op_a = a; op_b = b; sub = s; cin = ci;
    tick();                                   // E0
    // Scramble the inputs: the latched operands must be unaffected.
    start = 1'b0;
    op_a  = W'($urandom);
    op_b  = W'($urandom);
    sub   = 1'($urandom);
    cin   = 1'($urandom);
    for (int i = 0; i < NIBBLES; i++) begin
      check({tag, ".busy_run"}, 32'(busy), 32'd1);
      check({tag, ".done_run"}, 32'(done), 32'd0);
      seq_a[i] = add_a;
      seq_c[i] = add_c;
      tick();
    end
    check({tag, ".done"},      32'(done), 32'd1);
    check({tag, ".busy_done"}, 32'(busy), 32'd0);
    check({tag, ".sum"},       32'(sum),  32'(exp_sum));
    check({tag, ".cout"},      32'(cout), 32'(exp_cout));
    tick();
    check({tag, ".done_low"},  32'(done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [W:0]   ref_full;
    logic [W-1:0] ra, rb, exp_s;
    logic         rs, rc, exp_c;
    logic         saw_done;
    int           gap;

    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; op_a = '0; op_b = '0;
    tick();
    tick();

    // ---- reset state --------------------------------------------------------
    check("rst.busy",  32'(busy),  32'd0);
    check("rst.done",  32'(done),  32'd0);
    check("rst.sum",   32'(sum),   32'd0);
    check("rst.cout",  32'(cout),  32'd0);
    check("rst.add_a", 32'(add_a), 32'd0);
    check("rst.add_b", 32'(add_b), 32'd0);
    check("rst.add_c", 32'(add_c), 32'd0);
    rst = 1'b0;
    tick();

    // ---- add, no carry ------------------------------------------------------
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, "add");
    check("add.add_a_seq", 32'({seq_a[0], seq_a[1], seq_a[2], seq_a[3]}),
          32'h4321);

    // ---- full carry ripple --------------------------------------------------
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, "ripple");
    check("ripple.add_c_seq", 32'({seq_c[0], seq_c[1], seq_c[2], seq_c[3]}),
          32'b0111);

    // ---- carry-in and subtract ---------------------------------------------
    do_op(16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, "cin");
    do_op(16'h1000, 16'h0001, 1'b1, 1'b0, 16'h0FFF, 1'b1, "sub_nb");
    // cin must be ignored for subtract.
    do_op(16'h0001, 16'h0002, 1'b1, 1'b1, 16'hFFFF, 1'b0, "sub_borrow");
    check("sub_borrow.add_c_first", 32'(seq_c[0]), 32'd1);

    // ---- start while busy ---------------------------------------------------
    start = 1'b1; op_a = 16'h1111; op_b = 16'h2222; sub = 1'b0; cin = 1'b0;
    tick();                                   // E0
    start = 1'b0;
    tick();                                   // E0+1
    start = 1'b1; op_a = 16'hAAAA; op_b = 16'h5555; sub = 1'b1; cin = 1'b1;
    tick();                                   // E0+2: ignored
    start = 1'b0;
    tick();                                   // E0+3
    tick();                                   // E0+4: DONE cycle
    check("busy_ign.done", 32'(done), 32'd1);
    check("busy_ign.sum",  32'(sum),  32'h3333);
    check("busy_ign.cout", 32'(cout), 32'd0);
    start = 1'b1; op_a = 16'h0F00; op_b = 16'h00F0; sub = 1'b0; cin = 1'b0;
    tick();                                   // E0+5: ignored, back in IDLE
    check("busy_ign.idle_busy", 32'(busy), 32'd0);
    check("busy_ign.idle_done", 32'(done), 32'd0);
    check("busy_ign.sum_hold",  32'(sum),  32'h3333);
    tick();                                   // E0+6: accepted
    start = 1'b0;
    check("busy_ign.accept", 32'(busy), 32'd1);
    saw_done = 1'b0;
    for (int k = 0; k < 10 && !saw_done; k++) begin
      tick();
      saw_done = done;
    end
    check("busy_ign.second_done", 32'(saw_done), 32'd1);
    check("busy_ign.second_sum",  32'(sum),      32'h0FF0);
    check("busy_ign.second_cout", 32'(cout),     32'd0);
    tick();

    // ---- reset mid-operation ------------------------------------------------
    start = 1'b1; op_a = 16'hABCD; op_b = 16'h1111; sub = 1'b0; cin = 1'b0;
    tick();                                   // E0
    start = 1'b0;
    tick();                                   // E0+1
    rst = 1'b1;
    tick();                                   // E0+2
    check("midrst.busy",  32'(busy),  32'd0);
    check("midrst.done",  32'(done),  32'd0);
    check("midrst.sum",   32'(sum),   32'd0);
    check("midrst.cout",  32'(cout),  32'd0);
    check("midrst.add_a", 32'(add_a), 32'd0);
    check("midrst.add_b", 32'(add_b), 32'd0);
    check("midrst.add_c", 32'(add_c), 32'd0);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      saw_done = saw_done | done | busy;
    end
    check("midrst.no_activity", 32'(saw_done), 32'd0);
    do_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, "after_rst");

    // ---- random -------------------------------------------------------------
    for (int n = 0; n < 1000; n++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      rc = 1'($urandom);
      if (rs) begin
        exp_s = ra - rb;
        exp_c = (ra >= rb);
      end else begin
        ref_full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
        exp_s    = ref_full[W-1:0];
        exp_c    = ref_full[W];
      end
      do_op(ra, rb, rs, rc, exp_s, exp_c, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
